// File: rtl/lane_deskew_aligner_if.sv
// Lane-side data bus and status of the lane deskew aligner.
// master drives the raw lanes and clear; slave is the aligner.
interface lane_deskew_aligner_if #(
    parameter int NUM_LANES    = 8,
    parameter int LANE_WIDTH   = 64,
    parameter int LOG_MAX_SKEW = 3
);
    logic                            in_valid;
    logic [NUM_LANES*LANE_WIDTH-1:0] in_data;
    logic                            clear;
    logic                            out_valid;
    logic [NUM_LANES*LANE_WIDTH-1:0] out_data;
    logic                            aligned;
    logic [NUM_LANES-1:0]            lane_locked;
    logic [NUM_LANES-1:0]            lane_inverted;
    logic [LOG_MAX_SKEW-1:0]         skew_words;
    logic                            skew_err;

    modport master (
        output in_valid, in_data, clear,
        input  out_valid, out_data, aligned, lane_locked, lane_inverted, skew_words, skew_err
    );

    modport slave (
        input  in_valid, in_data, clear,
        output out_valid, out_data, aligned, lane_locked, lane_inverted, skew_words, skew_err
    );
endinterface

// File: rtl/lane_deskew_aligner.sv
// Per-lane circular buffers, first-marker lock per lane, simultaneous aligned readout.
// Build macro LANE_DESKEW_POLARITY_EN adds inverted-marker lock and output polarity correction.
module lane_deskew_aligner #(
    parameter int          NUM_LANES    = 8,
    parameter int          LANE_WIDTH   = 64,
    parameter int          LOG_MAX_SKEW = 3,
    parameter logic [15:0] MARKER       = 16'hF0C0
) (
    input  logic                 clk_hmc,
    input  logic                 res_n,
    lane_deskew_aligner_if.slave bus
);
    localparam int DEPTH = 1 << LOG_MAX_SKEW;
    localparam int CNT_W = LOG_MAX_SKEW + 1;

    typedef enum logic {SEARCH = 1'b0, ALIGNED = 1'b1} state_t;
    typedef logic [LOG_MAX_SKEW-1:0] ptr_t;

    state_t                          state, state_nxt;
    logic [LANE_WIDTH-1:0]           lane_buf [NUM_LANES][DEPTH];
    ptr_t                            wr_ptr;
    ptr_t                            lock_ptr [NUM_LANES];
    ptr_t                            rd_ptr   [NUM_LANES];
    logic [NUM_LANES-1:0]            locked;
    logic [CNT_W-1:0]                skew_cnt;
    logic [LOG_MAX_SKEW-1:0]         skew_words;
    logic                            skew_err;
    logic                            out_valid;
    logic [NUM_LANES*LANE_WIDTH-1:0] out_data;

    logic [NUM_LANES-1:0] match;
    logic [NUM_LANES-1:0] new_lock;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 lock_en, counting, first_lock, timeout, done;
`ifdef LANE_DESKEW_POLARITY_EN
    logic [NUM_LANES-1:0] match_inv;
    logic [NUM_LANES-1:0] inverted;
`endif

    always_comb begin
        match = '0;
`ifdef LANE_DESKEW_POLARITY_EN
        match_inv = '0;
`endif
        for (int k = 0; k < NUM_LANES; k++) begin
`ifdef LANE_DESKEW_POLARITY_EN
            match_inv[k] = (bus.in_data[k*LANE_WIDTH +: 16] == ~MARKER);
            match[k]     = (bus.in_data[k*LANE_WIDTH +: 16] == MARKER) || match_inv[k];
`else
            match[k]     = (bus.in_data[k*LANE_WIDTH +: 16] == MARKER);
`endif
        end
    end

    // clear outranks any marker seen in the same cycle
    assign lock_en    = (state == SEARCH) && bus.in_valid && !bus.clear;
    assign new_lock   = match & ~locked & {NUM_LANES{lock_en}};
    assign first_lock = (locked == '0) && (new_lock != '0);
    assign counting   = lock_en && (locked != '0);
    assign cnt_inc    = skew_cnt + 1'b1;
    // the timeout beats a late marker arriving in the same cycle
    assign timeout    = counting && (cnt_inc == CNT_W'(DEPTH));
    assign done       = lock_en && ((locked | new_lock) == '1) && !timeout;

    always_ff @(posedge clk_hmc or negedge res_n) begin
        if (!res_n) state <= SEARCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH:  if (done)      state_nxt = ALIGNED;
            ALIGNED: if (bus.clear) state_nxt = SEARCH;
            default:                state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk_hmc) begin
        if (bus.in_valid) begin
            for (int k = 0; k < NUM_LANES; k++)
                lane_buf[k][wr_ptr] <= bus.in_data[k*LANE_WIDTH +: LANE_WIDTH];
        end
    end

    always_ff @(posedge clk_hmc or negedge res_n) begin
        if (!res_n) begin
            wr_ptr     <= '0;
            locked     <= '0;
            skew_cnt   <= '0;
            skew_words <= '0;
            skew_err   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                lock_ptr[k] <= '0;
                rd_ptr[k]   <= '0;
            end
`ifdef LANE_DESKEW_POLARITY_EN
            inverted   <= '0;
`endif
        end else begin
            skew_err <= 1'b0;
            if (bus.in_valid) wr_ptr <= wr_ptr + 1'b1;

            if (bus.clear) begin
                locked     <= '0;
                skew_cnt   <= '0;
                skew_words <= '0;
                out_valid  <= 1'b0;
`ifdef LANE_DESKEW_POLARITY_EN
                inverted   <= '0;
`endif
            end else if (state == SEARCH) begin
                out_valid <= 1'b0;
                if (timeout) begin
                    skew_err <= 1'b1;
                    locked   <= '0;
                    skew_cnt <= '0;
`ifdef LANE_DESKEW_POLARITY_EN
                    inverted <= '0;
`endif
                end else begin
                    locked <= locked | new_lock;
`ifdef LANE_DESKEW_POLARITY_EN
                    inverted <= inverted | (new_lock & match_inv);
`endif
                    for (int k = 0; k < NUM_LANES; k++)
                        if (new_lock[k]) lock_ptr[k] <= wr_ptr;
                    if (first_lock)    skew_cnt <= '0;
                    else if (counting) skew_cnt <= cnt_inc;
                    if (done) begin
                        skew_words <= first_lock ? '0 : cnt_inc[LOG_MAX_SKEW-1:0];
                        for (int k = 0; k < NUM_LANES; k++)
                            rd_ptr[k] <= new_lock[k] ? wr_ptr : lock_ptr[k];
                    end
                end
            end else begin
                out_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    for (int k = 0; k < NUM_LANES; k++) begin
`ifdef LANE_DESKEW_POLARITY_EN
                        out_data[k*LANE_WIDTH +: LANE_WIDTH] <=
                            lane_buf[k][rd_ptr[k]] ^ {LANE_WIDTH{inverted[k]}};
`else
                        out_data[k*LANE_WIDTH +: LANE_WIDTH] <= lane_buf[k][rd_ptr[k]];
`endif
                        rd_ptr[k] <= rd_ptr[k] + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_data;
    assign bus.aligned     = (state == ALIGNED);
    assign bus.lane_locked = locked;
    assign bus.skew_words  = skew_words;
    assign bus.skew_err    = skew_err;
`ifdef LANE_DESKEW_POLARITY_EN
    assign bus.lane_inverted = inverted;
`else
    assign bus.lane_inverted = '0;
`endif
endmodule

// File: tb/tb_lane_deskew_aligner.sv
// Self-checking bench for lane_deskew_aligner: lanes carry a per-lane word stream with a marker,
// delayed and optionally inverted per lane; the expected output is the stream from its marker on.
`timescale 1ns/1ps
module tb_lane_deskew_aligner;
    localparam int          N     = 8;
    localparam int          W     = 64;
    localparam int          LS    = 3;
    localparam int          M_IDX = 2;
    localparam logic [15:0] MK    = 16'hF0C0;

    logic clk   = 1'b0;
    logic res_n = 1'b0;
    always #5 clk = ~clk;

    lane_deskew_aligner_if #(.NUM_LANES(N), .LANE_WIDTH(W), .LOG_MAX_SKEW(LS)) bus ();
    lane_deskew_aligner dut (.clk_hmc(clk), .res_n(res_n), .bus(bus));

    int          tests = 0;
    int          fails = 0;
    int          dly [N];
    logic [N-1:0] inv_mask;
    logic [31:0] seed;
    int          err_cycles;
    bit          saw_aligned;

    // uninverted source word n of lane k; index M_IDX carries the marker
    function automatic logic [W-1:0] src_word(int k, int n);
        logic [15:0] low;
        low = (n == M_IDX) ? MK : (16'h1200 + 16'(n & 255));
        return {seed + 32'(n) * 32'd2654435761, 8'(k), 8'(n), low};
    endfunction

    function automatic logic [W-1:0] in_word(int k, int v);
        logic [W-1:0] w;
        int n;
        n = v - dly[k];
        if (n < 0) w = {$urandom, 16'hAAAA, 16'h5555};
        else       w = src_word(k, n);
        if (inv_mask[k]) w = ~w;
        return w;
    endfunction

    function automatic logic [N-1:0] exp_inv();
`ifdef LANE_DESKEW_POLARITY_EN
        return inv_mask;
`else
        return '0;
`endif
    endfunction

    task automatic set_dly(input int d0, input int d1, input int d2, input int d3,
                           input int d4, input int d5, input int d6, input int d7);
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
        dly[4] = d4; dly[5] = d5; dly[6] = d6; dly[7] = d7;
    endtask

    // mode 0: in_valid always, 1: alternating, 2: random
    task automatic run_stream(input string name, input int n_goal, input int mode, input bit expect_align);
        int v = 0, cyc = 0, outs = 0, maxd = 0, mind = 1000, lst;
        bit vld, aligned_exp = 1'b0, want_ov;
        logic [N*W-1:0] exp_data;
        logic [W-1:0] fw;
        seed = $urandom;
        for (int k = 0; k < N; k++) begin
            if (dly[k] > maxd) maxd = dly[k];
            if (dly[k] < mind) mind = dly[k];
        end
        lst = M_IDX + maxd;
        err_cycles = 0;
        saw_aligned = 1'b0;
        while ((expect_align ? (outs < n_goal) : (cyc < n_goal)) && cyc < 400) begin
            case (mode)
                0:       vld = 1'b1;
                1:       vld = ((cyc % 2) == 0);
                default: vld = ($urandom_range(0, 1) == 1);
            endcase
            bus.clear = 1'b0;
            bus.in_valid = vld;
            for (int k = 0; k < N; k++) begin
                if (vld) bus.in_data[k*W +: W] = in_word(k, v);
                else begin
                    fw = {$urandom, $urandom};
                    fw[15:0] = MK;
                    bus.in_data[k*W +: W] = fw;
                end
            end
            @(posedge clk); #1;
            if (bus.aligned === 1'b1) saw_aligned = 1'b1;
            if (bus.skew_err === 1'b1) err_cycles++;
            if (expect_align) begin
                if (vld && v >= lst) aligned_exp = 1'b1;
                want_ov = vld && (v > lst);
                tests++;
                if (bus.aligned !== aligned_exp) begin
                    fails++;
                    $display("FAIL %s aligned cyc %0d got %b want %b", name, cyc, bus.aligned, aligned_exp);
                end
                tests++;
                if (bus.out_valid !== want_ov) begin
                    fails++;
                    $display("FAIL %s out_valid cyc %0d got %b want %b", name, cyc, bus.out_valid, want_ov);
                end
                tests++;
                if (bus.skew_err !== 1'b0) begin
                    fails++;
                    $display("FAIL %s skew_err cyc %0d got %b want 0", name, cyc, bus.skew_err);
                end
                if (want_ov) begin
                    for (int k = 0; k < N; k++)
                        exp_data[k*W +: W] = src_word(k, M_IDX + v - lst - 1);
                    tests++;
                    if (bus.out_data !== exp_data) begin
                        fails++;
                        $display("FAIL %s out_data word %0d got %h want %h", name, outs, bus.out_data, exp_data);
                    end
                    outs++;
                end
            end
            if (vld) v++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        if (expect_align) begin
            tests++;
            if (outs < n_goal) begin
                fails++;
                $display("FAIL %s timeout got %0d words want %0d", name, outs, n_goal);
            end
            tests++;
            if (bus.skew_words !== LS'(maxd - mind)) begin
                fails++;
                $display("FAIL %s skew_words got %0d want %0d", name, bus.skew_words, maxd - mind);
            end
            tests++;
            if (bus.lane_locked !== {N{1'b1}}) begin
                fails++;
                $display("FAIL %s lane_locked got %h want ff", name, bus.lane_locked);
            end
            tests++;
            if (bus.lane_inverted !== exp_inv()) begin
                fails++;
                $display("FAIL %s lane_inverted got %h want %h", name, bus.lane_inverted, exp_inv());
            end
        end
    endtask

    // clear pulse carrying a marker on every lane; the markers must not lock
    task automatic do_clear();
        bus.clear = 1'b1;
        bus.in_valid = 1'b1;
        for (int k = 0; k < N; k++) bus.in_data[k*W +: W] = {$urandom, 16'h0, MK};
        @(posedge clk); #1;
        bus.clear = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        tests++;
        if ({bus.out_valid, bus.aligned, bus.skew_err, bus.skew_words, bus.lane_locked, bus.lane_inverted} !== '0) begin
            fails++;
            $display("FAIL %s status got ov=%b al=%b err=%b skew=%0d lock=%h inv=%h want all 0", name,
                     bus.out_valid, bus.aligned, bus.skew_err, bus.skew_words, bus.lane_locked, bus.lane_inverted);
        end
        tests++;
        if (bus.out_data !== '0) begin
            fails++;
            $display("FAIL %s out_data got %h want 0", name, bus.out_data);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.clear = 1'b0;
        bus.in_data = '0;
        inv_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        res_n = 1'b1;
    endtask

    task automatic test_same_cycle();
        do_clear();
        set_dly(0, 0, 0, 0, 0, 0, 0, 0);
        run_stream("same_cycle", 12, 0, 1'b1);
    endtask

    task automatic test_lane3_delay();
        do_clear();
        set_dly(0, 0, 0, 5, 0, 0, 0, 0);
        run_stream("lane3_delay", 12, 0, 1'b1);
    endtask

    task automatic test_polarity();
        do_clear();
        set_dly(0, 0, 0, 0, 0, 0, 0, 0);
        inv_mask = 8'h04;
`ifdef LANE_DESKEW_POLARITY_EN
        run_stream("polarity", 10, 0, 1'b1);
`else
        run_stream("polarity_off", 24, 0, 1'b0);
        tests++;
        if (err_cycles != 1) begin
            fails++;
            $display("FAIL polarity_off skew_err cycles got %0d want 1", err_cycles);
        end
        tests++;
        if (saw_aligned) begin
            fails++;
            $display("FAIL polarity_off aligned got 1 want 0");
        end
`endif
        inv_mask = '0;
    endtask

    task automatic test_skew_timeout();
        do_clear();
        set_dly(0, 0, 0, 0, 0, 0, 0, 8);
        run_stream("skew_timeout", 24, 0, 1'b0);
        tests++;
        if (err_cycles != 1) begin
            fails++;
            $display("FAIL skew_timeout skew_err cycles got %0d want 1", err_cycles);
        end
        tests++;
        if (saw_aligned || bus.lane_locked !== '0) begin
            fails++;
            $display("FAIL skew_timeout state got aligned=%b lock=%h want 0 and 00", saw_aligned, bus.lane_locked);
        end
        set_dly(0, 0, 0, 0, 0, 0, 0, 7);
        run_stream("skew_recover", 10, 0, 1'b1);
    endtask

    task automatic test_valid_toggle();
        do_clear();
        set_dly(1, 0, 2, 0, 3, 0, 1, 0);
        run_stream("valid_toggle", 10, 1, 1'b1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            do_clear();
            for (int k = 0; k < N; k++) dly[k] = int'($urandom_range(0, 7));
`ifdef LANE_DESKEW_POLARITY_EN
            inv_mask = N'($urandom);
`else
            inv_mask = '0;
`endif
            run_stream("random", 12, 2, 1'b1);
        end
        inv_mask = '0;
    endtask

    task automatic test_clear_reset();
        do_clear();
        set_dly(0, 3, 0, 0, 0, 0, 0, 0);
        run_stream("pre_clear", 4, 0, 1'b1);
        do_clear();
        tests++;
        if ({bus.aligned, bus.out_valid, bus.skew_words, bus.lane_locked} !== '0) begin
            fails++;
            $display("FAIL clear got al=%b ov=%b skew=%0d lock=%h want all 0",
                     bus.aligned, bus.out_valid, bus.skew_words, bus.lane_locked);
        end
        set_dly(2, 0, 0, 0, 0, 0, 4, 0);
        run_stream("after_clear", 6, 0, 1'b1);
        res_n = 1'b0;
        #2;
        check_all_zero("async_reset");
        @(posedge clk); #1;
        res_n = 1'b1;
        set_dly(0, 0, 6, 0, 0, 1, 0, 0);
        run_stream("after_reset", 10, 0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_lane3_delay();
        test_polarity();
        test_skew_timeout();
        test_valid_toggle();
        test_random();
        test_clear_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lane_deskew_aligner.md
# lane_deskew_aligner

Receive-side lane deskew and polarity-recovery block in the `clk_hmc` domain, placed between the per-lane deserializer words and the link-layer RX datapath. It undoes the impairments the serial routing stage injects on the way to the controller: per-lane word delay and per-lane polarity inversion. Each lane is buffered in a small circular store, and each lane's first alignment marker is located. Once every lane has locked, all lanes are read out from their marker positions simultaneously as one word-aligned, polarity-corrected bus.

## Interface
Parameters:
- `NUM_LANES`, 8, number of serial lanes
- `LANE_WIDTH`, 64, bits per lane word per `clk_hmc` cycle
- `LOG_MAX_SKEW`, 3, log2 of the per-lane buffer depth; maximum tolerated skew is 2**LOG_MAX_SKEW-1 valid words
- `MARKER`, 16'hF0C0, alignment marker matched on lane word bits [15:0]

Ports:
- `clk_hmc`  in  1  block clock
- `res_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  `in_data` holds a valid word on all lanes
- `in_data`  in  NUM_LANES*LANE_WIDTH  lane k occupies bits [k*LANE_WIDTH +: LANE_WIDTH]
- `clear`  in  1  synchronous pulse; returns the block to SEARCH
- `out_valid`  out  1  `out_data` holds an aligned word
- `out_data`  out  NUM_LANES*LANE_WIDTH  deskewed, polarity-corrected lanes
- `aligned`  out  1  high while in ALIGNED
- `lane_locked`  out  NUM_LANES  lane marker found
- `lane_inverted`  out  NUM_LANES  lane detected as inverted
- `skew_words`  out  LOG_MAX_SKEW  valid words between first and last lane lock
- `skew_err`  out  1  one-cycle pulse on skew timeout

## Operation
- The per-lane circular buffer has depth 2**LOG_MAX_SKEW, with a shared write pointer `wr_ptr`.
- Every `in_valid` cycle: write each lane word at `wr_ptr`, then `wr_ptr++` (wraps modulo depth). Writes continue in all states.
- States: SEARCH, ALIGNED.
- **SEARCH:**
  - A lane locks on its first valid word whose [15:0] == `MARKER`. With polarity detection compiled in, it also locks on [15:0] == ~`MARKER` and sets `lane_inverted`.
  - On lock, latch `lock_ptr[k] = wr_ptr`.
  - Once locked, a lane ignores further markers.
  - Skew counter: cleared on the first lock, then incremented on each `in_valid` cycle while some lanes are unlocked.
  - If the counter reaches 2**LOG_MAX_SKEW while any lane is unlocked: pulse `skew_err`, clear all `lane_locked`, `lane_inverted` and the counter, and stay in SEARCH.
  - When the last lane locks: load `rd_ptr[k] = lock_ptr[k]`, set `skew_words` = counter, go to ALIGNED.
  - Lanes that match in the same cycle lock together. If every lane locks in one cycle, `skew_words` = 0.
- **ALIGNED:**
  - Each `in_valid` cycle: `out_data` lane k <= buf[k][rd_ptr[k]], XOR all-ones if `lane_inverted[k]`; `rd_ptr[k]++`; `out_valid` <= 1.
  - Otherwise `out_valid` <= 0 and `out_data` holds.
  - Markers are ignored.
  - The read/write distance per lane is constant and below the depth, so no overrun is possible.
- **`clear`** in any state: next cycle is SEARCH, with locks, inverted flags, `skew_words`, `aligned` and `out_valid` cleared. The `wr_ptr` is not cleared.
- **`clear` together with a marker in the same cycle:** `clear` wins and the marker is not latched.

## Timing
- All outputs are registered.
- Reset values: every output is 0, including `out_data`; state is SEARCH and `wr_ptr` is 0.
- The marker of the last-locking lane is present in cycle t. Then:
  - `aligned` = 1 from cycle t+1.
  - The first read happens on the first `in_valid` cycle at or after t+1, and `out_valid` rises one cycle later.
  - The first output word contains every lane's marker word, corrected to `MARKER`.
- Steady-state latency is 1 cycle from an `in_valid` read cycle to `out_valid`.
- `skew_err` is a single-cycle pulse, in the cycle after the counter reaches 2**LOG_MAX_SKEW.
- `res_n` asserted mid-operation clears everything asynchronously. After deassertion, the block searches afresh.

## Configuration
- `LANE_DESKEW_POLARITY_EN` defined:
  - Inverted markers are accepted.
  - `lane_inverted` is driven.
  - Inverted lanes are XOR-corrected on output.
- Undefined:
  - Only a true `MARKER` locks a lane.
  - `lane_inverted` is tied to 0.
  - There is no output XOR.

## Test plan
- All 8 lanes present `MARKER` in the same cycle, `in_valid` constant 1 -> `aligned` rises 1 cycle later; `skew_words` = 0; the first `out_valid` word has 16'hF0C0 on every lane, followed by in-order data.
- Lane 3 delayed by 5 words, other lanes delayed by 0 -> `skew_words` = 5; output lanes are word-aligned (counter payload identical across lanes each cycle).
- Lane 2 inverted, with `LANE_DESKEW_POLARITY_EN` defined -> `lane_inverted` = 8'h04; lane 2 output equals the uninverted payload. Same stimulus with the macro undefined -> lane 2 never locks and `skew_err` pulses.
- Lane 7 marker 8 words after lane 0's -> `skew_err` pulses once, state returns to SEARCH; a subsequent in-skew marker set aligns normally.
- `in_valid` toggling 1,0,1,0 in ALIGNED -> `out_valid` mirrors it delayed by 1 cycle, with no data dropped or duplicated.
- Assert `clear`, then `res_n` low mid-ALIGNED -> next cycle all outputs are 0; realignment succeeds on the next marker set.
